// File: rtl/image_reject_fir_pkg.sv
// fir_pkg: coefficient table plus rounding and saturation constants
// shared by the anti-imaging FIR and the downstream decimator.
package fir_pkg;

  localparam int NUM_TAPS_DEFAULT = 15;

  typedef logic signed [15:0] coeff_t;

  // Every polyphase branch (k mod 3) sums to 32768, so x,0,0 passes at unity.
  localparam coeff_t COEFFS [0:NUM_TAPS_DEFAULT-1] = '{
    16'sd268,
    16'sd0,
    -16'sd3000,
    -16'sd4500,
    16'sd1,
    16'sd13000,
    16'sd27000,
    16'sd32766,
    16'sd27000,
    16'sd13000,
    16'sd1,
    -16'sd4500,
    -16'sd3000,
    16'sd0,
    16'sd268
  };

  localparam int ROUND_SHIFT = 15;
  localparam int ROUND_CONST = 1 << (ROUND_SHIFT - 1);
  localparam int SAT_MAX     = 32767;
  localparam int SAT_MIN     = -32768;

  function automatic coeff_t coeff_at(input int k);
    return (k < NUM_TAPS_DEFAULT) ? COEFFS[k] : '0;
  endfunction

endpackage

// File: rtl/image_reject_fir_if.sv
// image_reject_fir_if: sample stream into and out of the FIR.
// fir_ovf is present only when FIR_OVF_FLAG_EN is defined.
interface image_reject_fir_if #(
  parameter int DATA_WIDTH = 16
);

  logic signed [DATA_WIDTH-1:0] fir_in;
  logic                         fir_in_valid;
  logic signed [DATA_WIDTH-1:0] fir_out;
  logic                         fir_out_valid;

`ifdef FIR_OVF_FLAG_EN
  logic                         fir_ovf;

  modport master (
    output fir_in,
    output fir_in_valid,
    input  fir_out,
    input  fir_out_valid,
    input  fir_ovf
  );

  modport slave (
    input  fir_in,
    input  fir_in_valid,
    output fir_out,
    output fir_out_valid,
    output fir_ovf
  );
`else
  modport master (
    output fir_in,
    output fir_in_valid,
    input  fir_out,
    input  fir_out_valid
  );

  modport slave (
    input  fir_in,
    input  fir_in_valid,
    output fir_out,
    output fir_out_valid
  );
`endif

endinterface

// File: rtl/image_reject_fir_sat_round.sv
// sat_round: half-up rounding of a Q-scaled accumulator to DATA_WIDTH
// with saturation; combinational, ovf flags a clipped result.
module sat_round
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH  = 36,
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int SW = ACC_WIDTH - ROUND_SHIFT;

  logic signed [ACC_WIDTH-1:0] rnd;
  logic signed [SW-1:0]        shr;
  logic                        hi;
  logic                        lo;

  always_comb begin
    rnd = acc + ACC_WIDTH'(ROUND_CONST);
    shr = SW'(rnd >>> ROUND_SHIFT);
    hi  = shr > SW'(SAT_MAX);
    lo  = shr < SW'(SAT_MIN);
    ovf = hi | lo;
    unique case (1'b1)
      hi:      dout = DATA_WIDTH'(SAT_MAX);
      lo:      dout = DATA_WIDTH'(SAT_MIN);
      default: dout = shr[DATA_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/image_reject_fir.sv
// image_reject_fir: direct-form anti-imaging FIR after the L=3 zero-stuffer,
// 2-stage pipeline. FIR_OVF_FLAG_EN adds the sticky fir_ovf flag.
module image_reject_fir
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = NUM_TAPS_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clk_enable,
  image_reject_fir_if.slave bus
);

  localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] p_q [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] p_d [NUM_TAPS];
  logic                         v1_q;
  logic                         v1_d;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic signed [DATA_WIDTH-1:0] out_d;
  logic                         out_v_q;
  logic                         out_v_d;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] sat_out;

  // Products are taken from the post-shift line, so the new sample
  // reaches stage 1 on the cycle it is accepted.
  always_comb begin
    x_d     = x_q;
    p_d     = p_q;
    v1_d    = v1_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    if (clk_enable) begin
      if (bus.fir_in_valid) begin
        x_d[0] = bus.fir_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
          x_d[k] = x_q[k-1];
        end
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_d[k] = PROD_WIDTH'(x_d[k])
               * PROD_WIDTH'(COEFF_WIDTH'(coeff_at(k)));
      end
      v1_d    = bus.fir_in_valid;
      out_v_d = v1_q;
      if (v1_q) begin
        out_d = sat_out;
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc = acc + ACC_WIDTH'(p_q[k]);
    end
  end

`ifdef FIR_OVF_FLAG_EN
  logic sat_ovf;
  logic ovf_q;
  logic ovf_d;

  sat_round #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat (
    .acc  (acc),
    .dout (sat_out),
    .ovf  (sat_ovf)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (clk_enable && v1_q && sat_ovf) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.fir_ovf = ovf_q;
`else
  logic sat_ovf_unused;

  sat_round #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat (
    .acc  (acc),
    .dout (sat_out),
    .ovf  (sat_ovf_unused)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
        p_q[k] <= '0;
      end
      v1_q    <= 1'b0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      p_q     <= p_d;
      v1_q    <= v1_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
    end
  end

  assign bus.fir_out       = out_q;
  assign bus.fir_out_valid = out_v_q;

endmodule
